// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial receiver for parity-protected data words.
// Frame: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
// Checks parity and framing, presents each word on a valid/ready register and
// keeps a saturating count of bad frames.
// Optional: define PARITY_RX_STICKY_ERR_EN to add the sticky_err output.

`timescale 1ns/1ps

module parity_frame_rx #(
   parameter int DATA_W     = 7,
   parameter bit ODD_PARITY = 1'b0,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bit_valid,
   input  logic                 serial_in,
   input  logic                 out_ready,
   input  logic                 clr_count,
   output logic                 out_valid,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_perr,
   output logic                 out_ferr,
   output logic                 overrun,
   output logic [ERR_CNT_W-1:0] err_count,
`ifdef PARITY_RX_STICKY_ERR_EN
   output logic                 sticky_err,
`endif
   output logic                 busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_PAR  = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   // A mismatch is a data+parity XOR that differs from the expected polarity.
   function automatic logic calc_perr(input logic [DATA_W-1:0] data, input logic p_rx);
      return (((^data) ^ p_rx) != ODD_PARITY);
   endfunction

   state_t             state_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [DATA_W-1:0]  shift_q;
   logic               perr_q;
   logic               ferr_q;
   logic               done_q;

   logic               out_valid_q;
   logic [DATA_W-1:0]  out_data_q;
   logic               out_perr_q;
   logic               out_ferr_q;
   logic               overrun_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic [ERR_CNT_W-1:0] err_cnt_d;
   logic               frame_bad_s;

   assign frame_bad_s = done_q & (perr_q | ferr_q);

   // Frame FSM: advances one step per qualified bit, flags a finished frame in done_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bit_valid) begin
            case (state_q)
               ST_IDLE: begin
                  if (!serial_in) begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                     shift_q   <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_DATA: begin
                  shift_q[bit_cnt_q] <= serial_in;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= ST_PAR;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end
               ST_PAR: begin
                  perr_q  <= calc_perr(shift_q, serial_in);
                  state_q <= ST_STOP;
               end
               ST_STOP: begin
                  ferr_q  <= ~serial_in;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Output word register: load on completion unless a word is stuck, else drop and flag overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_perr_q  <= 1'b0;
         out_ferr_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (done_q) begin
            if (out_valid_q && !out_ready) begin
               overrun_q <= 1'b1;
            end else begin
               out_valid_q <= 1'b1;
               out_data_q  <= shift_q;
               out_perr_q  <= perr_q;
               out_ferr_q  <= ferr_q;
            end
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= out_valid_q;
         end
      end
   end

   // Error counter next state: clear beats increment, increment saturates.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (clr_count) begin
         err_cnt_d = '0;
      end else if (frame_bad_s && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Error counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

`ifdef PARITY_RX_STICKY_ERR_EN
   logic sticky_q;

   // Sticky error flag: set by any bad frame, held until cleared; clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sticky_q <= 1'b0;
      end else if (clr_count) begin
         sticky_q <= 1'b0;
      end else if (frame_bad_s) begin
         sticky_q <= 1'b1;
      end else begin
         sticky_q <= sticky_q;
      end
   end

   assign sticky_err = sticky_q;
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_perr  = out_perr_q;
   assign out_ferr  = out_ferr_q;
   assign overrun   = overrun_q;
   assign err_count = err_cnt_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx. Inputs change on the falling edge, outputs
// are sampled on the falling edge, so the rising edge in between samples them.
// A second instance with ERR_CNT_W=2 shares the stimulus for saturation checks.

`timescale 1ns/1ps

module tb_parity_frame_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bit_valid = 1'b0;
   logic       serial_in = 1'b1;
   logic       out_ready = 1'b0;
   logic       clr_count = 1'b0;

   logic       out_valid;
   logic [6:0] out_data;
   logic       out_perr;
   logic       out_ferr;
   logic       overrun;
   logic [7:0] err_count;
   logic       busy;

   logic       s_out_valid;
   logic [6:0] s_out_data;
   logic       s_out_perr;
   logic       s_out_ferr;
   logic       s_overrun;
   logic [1:0] s_err_count;
   logic       s_busy;
`ifdef PARITY_RX_STICKY_ERR_EN
   logic       sticky_err;
   logic       s_sticky_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   parity_frame_rx dut (
      .clk(clk), .reset(reset), .bit_valid(bit_valid), .serial_in(serial_in),
      .out_ready(out_ready), .clr_count(clr_count), .out_valid(out_valid),
      .out_data(out_data), .out_perr(out_perr), .out_ferr(out_ferr),
      .overrun(overrun), .err_count(err_count),
`ifdef PARITY_RX_STICKY_ERR_EN
      .sticky_err(sticky_err),
`endif
      .busy(busy)
   );

   parity_frame_rx #(.ERR_CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .bit_valid(bit_valid), .serial_in(serial_in),
      .out_ready(out_ready), .clr_count(clr_count), .out_valid(s_out_valid),
      .out_data(s_out_data), .out_perr(s_out_perr), .out_ferr(s_out_ferr),
      .overrun(s_overrun), .err_count(s_err_count),
`ifdef PARITY_RX_STICKY_ERR_EN
      .sticky_err(s_sticky_err),
`endif
      .busy(s_busy)
   );

   task automatic drive(input logic v, input logic b);
      bit_valid = v;
      serial_in = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1);
   endtask

   task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
      drive(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, d[i]);
      drive(1'b1, p);
      drive(1'b1, s);
      bit_valid = 1'b0;
      serial_in = 1'b1;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(2);
      n_checks++;
      if ({out_valid, out_data, out_perr, out_ferr, overrun, err_count, busy} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%0b d=%h pe=%0b fe=%0b ov=%0b cnt=%0d busy=%0b, want all 0",
                  out_valid, out_data, out_perr, out_ferr, overrun, err_count, busy);
      end
      reset = 1'b0;
      idle(1);
   endtask

   task automatic test_good_frame();
      send_frame(7'h53, 1'b0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL good_latency: out_valid=%0b want 0 at stop edge", out_valid);
      end
      idle(1);
      n_checks++;
      if ({out_valid, out_data, out_perr, out_ferr, err_count} !== {1'b1, 7'h53, 1'b0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL good_frame: v=%0b d=%h pe=%0b fe=%0b cnt=%0d, want v=1 d=53 pe=0 fe=0 cnt=0",
                  out_valid, out_data, out_perr, out_ferr, err_count);
      end
      accept();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL good_accept: out_valid=%0b want 0", out_valid);
      end
   endtask

   task automatic test_bad_frames();
      send_frame(7'h53, 1'b1, 1'b1);
      idle(1);
      n_checks++;
      if ({out_valid, out_perr, out_ferr, err_count} !== {1'b1, 1'b1, 1'b0, 8'd1}) begin
         n_fail++;
         $display("FAIL bad_parity: v=%0b pe=%0b fe=%0b cnt=%0d, want v=1 pe=1 fe=0 cnt=1",
                  out_valid, out_perr, out_ferr, err_count);
      end
      accept();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bad_parity_accept: out_valid=%0b want 0", out_valid);
      end
      send_frame(7'h53, 1'b0, 1'b0);
      idle(1);
      n_checks++;
      if ({out_valid, out_perr, out_ferr, err_count} !== {1'b1, 1'b0, 1'b1, 8'd2}) begin
         n_fail++;
         $display("FAIL bad_stop: v=%0b pe=%0b fe=%0b cnt=%0d, want v=1 pe=0 fe=1 cnt=2",
                  out_valid, out_perr, out_ferr, err_count);
      end
      accept();
   endtask

   task automatic test_gapped();
      logic [9:0] bits;
      // start, data 7'h2A LSB first, parity 1, stop
      bits = {1'b1, 1'b1, 7'h2A, 1'b0};
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_line_busy: busy=%0b want 0", busy);
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, bits[i]);
         if (i < 9) begin
            drive(1'b0, 1'b0);
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++; $display("FAIL gap_busy[%0d]: busy=%0b want 1", i, busy);
            end
         end
      end
      bit_valid = 1'b0;
      idle(1);
      n_checks++;
      if ({out_valid, out_data, out_perr, out_ferr, busy} !== {1'b1, 7'h2A, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL gapped_frame: v=%0b d=%h pe=%0b fe=%0b busy=%0b, want v=1 d=2a pe=0 fe=0 busy=0",
                  out_valid, out_data, out_perr, out_ferr, busy);
      end
      accept();
   endtask

   task automatic test_back_to_back();
      send_frame(7'h11, 1'b0, 1'b1);
      send_frame(7'h22, 1'b0, 1'b1);
      idle(1);
      n_checks++;
      if ({overrun, out_valid, out_data, err_count} !== {1'b1, 1'b1, 7'h11, 8'd2}) begin
         n_fail++;
         $display("FAIL overrun_pulse: ov=%0b v=%0b d=%h cnt=%0d, want ov=1 v=1 d=11 cnt=2",
                  overrun, out_valid, out_data, err_count);
      end
      idle(1);
      n_checks++;
      if ({overrun, out_data} !== {1'b0, 7'h11}) begin
         n_fail++; $display("FAIL overrun_one_cycle: ov=%0b d=%h, want ov=0 d=11", overrun, out_data);
      end
      accept();
      send_frame(7'h11, 1'b0, 1'b1);
      send_frame(7'h22, 1'b0, 1'b1);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      n_checks++;
      if ({out_valid, out_data, overrun} !== {1'b1, 7'h22, 1'b0}) begin
         n_fail++;
         $display("FAIL load_with_accept: v=%0b d=%h ov=%0b, want v=1 d=22 ov=0", out_valid, out_data, overrun);
      end
      idle(1);
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, 7'h22}) begin
         n_fail++; $display("FAIL hold_after_load: v=%0b d=%h, want v=1 d=22", out_valid, out_data);
      end
      accept();
   endtask

   task automatic test_saturation();
      clr_count = 1'b1;
      idle(1);
      clr_count = 1'b0;
      n_checks++;
      if ({s_err_count, err_count} !== {2'd0, 8'd0}) begin
         n_fail++; $display("FAIL clear_idle: sat=%0d main=%0d, want 0 0", s_err_count, err_count);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_frame(7'h53, 1'b1, 1'b1);
      idle(1);
      n_checks++;
      if ({s_err_count, err_count} !== {2'd3, 8'd5}) begin
         n_fail++; $display("FAIL saturate: sat=%0d main=%0d, want 3 5", s_err_count, err_count);
      end
      send_frame(7'h53, 1'b1, 1'b1);
      clr_count = 1'b1;
      idle(1);
      clr_count = 1'b0;
      n_checks++;
      if ({s_err_count, err_count} !== {2'd0, 8'd0}) begin
         n_fail++; $display("FAIL clear_wins: sat=%0d main=%0d, want 0 0", s_err_count, err_count);
      end
      idle(1);
      out_ready = 1'b0;
      n_checks++;
      if ({s_err_count, err_count} !== {2'd0, 8'd0}) begin
         n_fail++; $display("FAIL clear_hold: sat=%0d main=%0d, want 0 0", s_err_count, err_count);
      end
   endtask

   task automatic test_reset_mid_frame();
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      bit_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, out_valid} !== 2'b00) begin
         n_fail++; $display("FAIL async_reset: busy=%0b v=%0b, want 0 0", busy, out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      idle(1);
      send_frame(7'h7F, 1'b1, 1'b1);
      idle(1);
      n_checks++;
      if ({out_valid, out_data, out_perr, out_ferr, err_count} !== {1'b1, 7'h7F, 1'b0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL after_reset_frame: v=%0b d=%h pe=%0b fe=%0b cnt=%0d, want v=1 d=7f pe=0 fe=0 cnt=0",
                  out_valid, out_data, out_perr, out_ferr, err_count);
      end
      accept();
   endtask

`ifdef PARITY_RX_STICKY_ERR_EN
   task automatic test_sticky();
      out_ready = 1'b1;
      send_frame(7'h11, 1'b0, 1'b1);
      idle(1);
      n_checks++;
      if (sticky_err !== 1'b0) begin
         n_fail++; $display("FAIL sticky_good: sticky=%0b want 0", sticky_err);
      end
      send_frame(7'h11, 1'b1, 1'b1);
      idle(1);
      n_checks++;
      if (sticky_err !== 1'b1) begin
         n_fail++; $display("FAIL sticky_set: sticky=%0b want 1", sticky_err);
      end
      send_frame(7'h22, 1'b0, 1'b1);
      send_frame(7'h7F, 1'b1, 1'b1);
      idle(2);
      n_checks++;
      if (sticky_err !== 1'b1) begin
         n_fail++; $display("FAIL sticky_hold: sticky=%0b want 1", sticky_err);
      end
      send_frame(7'h11, 1'b1, 1'b1);
      clr_count = 1'b1;
      idle(1);
      clr_count = 1'b0;
      n_checks++;
      if (sticky_err !== 1'b0) begin
         n_fail++; $display("FAIL sticky_clear: sticky=%0b want 0", sticky_err);
      end
      out_ready = 1'b0;
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_bad_frames();
      test_gapped();
      test_back_to_back();
      test_saturation();
      test_reset_mid_frame();
`ifdef PARITY_RX_STICKY_ERR_EN
      test_sticky();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial receiver for 7-bit parity-protected data words.
- Frame order: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
- Recomputes parity on the received data, flags parity and framing errors, and presents each word on a valid/ready output register.
- Keeps a saturating error count. It is the receive end of the parity-generation path, used in hardware to check words produced by the Davio/conventional parity generators.

Parameters:
- DATA_W, 7, number of data bits per frame.
- ODD_PARITY, 0; 0 means the even-parity bit is expected (XOR of data plus parity bit = 0), 1 means odd parity is expected.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- bit_valid  input  1  qualifies serial_in for this cycle; no sampling when low.
- serial_in  input  1  serial line bit.
- out_ready  input  1  consumer accepts the output word.
- clr_count  input  1  synchronous clear of err_count.
- out_valid  output  1  output word held and valid.
- out_data  output  DATA_W  received data word.
- out_perr  output  1  parity mismatch for out_data.
- out_ferr  output  1  stop bit was 0 for out_data.
- overrun  output  1  one-cycle pulse; a completed frame was dropped.
- err_count  output  ERR_CNT_W  count of frames with perr or ferr, saturating.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, any cycle, including mid-frame):
  - FSM returns to IDLE; bit counter and shift register are cleared.
  - out_valid, out_data, out_perr, out_ferr, overrun, err_count and busy are all 0.
  - A partial frame is discarded.
- FSM states: IDLE, DATA, PAR, STOP. Transitions happen only on cycles where bit_valid=1; with bit_valid=0 all state holds.
- IDLE: serial_in=0 moves to DATA with bit_cnt=0. serial_in=1 stays in IDLE (idle line).
- DATA: the bit is stored at shift_reg[bit_cnt]. When bit_cnt=DATA_W-1, move to PAR; otherwise increment bit_cnt.
- PAR: capture p_rx. perr = (^shift_reg ^ p_rx) != ODD_PARITY. Move to STOP.
- STOP: ferr = ~serial_in. A complete frame is produced and the FSM moves to IDLE in the same edge. There is no wait for an idle line.
- Output register:
  - Load: on frame completion, out_data, out_perr, out_ferr and out_valid=1 are loaded one edge after the stop bit is sampled. Latency from stop-bit sample to out_valid is 1 cycle.
  - Accept: out_valid clears on an edge where out_valid and out_ready are both 1.
  - Completion and accept in the same cycle: the new frame loads and out_valid stays 1.
  - Completion while out_valid=1 and out_ready=0: the new frame is dropped, the held word is unchanged, and overrun pulses high for 1 cycle.
  - Dropped frames still update err_count.
- err_count:
  - Increments by 1 on each completed frame with perr|ferr, and saturates at 2^ERR_CNT_W-1.
  - clr_count=1 sets it to 0; clear wins over a simultaneous increment.
- busy=1 whenever the state is not IDLE.

Optional Feature:
- Macro PARITY_RX_STICKY_ERR_EN.
- When defined:
  - Adds output port sticky_err (1 bit, reset 0).
  - sticky_err sets on any completed frame with perr|ferr and stays set until clr_count=1.
  - Clear wins over a simultaneous set.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Even-parity good frame, defaults. Stimulus: 0, data 7'b1010011 LSB first (1,1,0,0,1,0,1), parity 0, stop 1, all with bit_valid=1. Required response: out_valid=1 one cycle after the stop bit, out_data=7'h53, out_perr=0, out_ferr=0, err_count=0.
- Bad parity. Stimulus: same frame with parity 1, then out_ready=1. Required response: out_perr=1, err_count=1; out_valid drops the cycle after accept. Repeat with stop bit 0: out_ferr=1, err_count=2.
- Gapped bits and idle line. Stimulus: 5 idle 1s, then frame 7'h2A (parity 1) with bit_valid=0 inserted between every bit. Required response: out_data=7'h2A, out_perr=0; busy stays high through the gaps.
- Overrun and simultaneous accept. Stimulus: two back-to-back good frames 7'h11 then 7'h22 with out_ready=0. Required response: out_data stays 7'h11 and overrun pulses 1 cycle. Then repeat with out_ready=1 asserted on the completion cycle of the second frame: out_data=7'h22 and out_valid stays 1.
- Saturation and clear, ERR_CNT_W=2. Stimulus: 5 bad-parity frames. Required response: err_count=3 held. Then pulse clr_count in the same cycle as a 6th bad frame completes: err_count=0.
- Reset mid-frame and sticky flag. Stimulus: assert reset after 3 data bits, then send good frame 7'h7F. Required response: out_data=7'h7F with no stale bits. With PARITY_RX_STICKY_ERR_EN defined: sticky_err=0 until a bad frame, then stays 1 across following good frames until clr_count.
